// File: rtl/axis_rgb_window3x3_pkg.sv
// Shared widths, default frame geometry and window bit-offset helper for the
// 3x3 RGB window generator.
package axis_rgb_window3x3_pkg;

    localparam int PIX_W     = 24;
    localparam int WIN_N     = 9;
    localparam int WIN_W     = PIX_W * WIN_N;
    localparam int IMG_W_DEF = 32;
    localparam int IMG_H_DEF = 32;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [WIN_W-1:0] window_t;

    // Element k = 3*r + c, r=0 is the top (oldest) row, c=0 the leftmost column.
    function automatic int winOffset(input int r, input int c);
        return PIX_W * (3 * r + c);
    endfunction

endpackage

// File: rtl/axis_rgb_window3x3_if.sv
// AXI-Stream style handshake bundle used for both the pixel input and the
// window output of axis_rgb_window3x3.
interface axis_rgb_window3x3_if
    import axis_rgb_window3x3_pkg::*;
#(
    parameter int DATA_W = PIX_W
);
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tready;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_rgb_window3x3_line_buffer2.sv
// Two stacked row buffers of IMG_W pixels: combinational read at the current
// column, and on write the older row takes the newer row's pixel.
module axis_line_buffer2
    import axis_rgb_window3x3_pkg::*;
#(
    parameter int  IMG_W = IMG_W_DEF,
    localparam int COL_W = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             wrEn_i,
    input  logic [COL_W-1:0] col_i,
    input  pixel_t           pix_i,
    output pixel_t           lb0_o,
    output pixel_t           lb1_o
);

    pixel_t lb0_q [IMG_W];
    pixel_t lb1_q [IMG_W];

    assign lb0_o = lb0_q[col_i];
    assign lb1_o = lb1_q[col_i];

    // No reset: contents are only trusted once two fresh rows have been written.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            lb1_q[col_i] <= lb0_q[col_i];
            lb0_q[col_i] <= pix_i;
        end
    end

endmodule

// File: rtl/axis_rgb_window3x3.sv
// Raster RGB stream to 3x3 neighbourhood stream (valid positions only).
// Optional macro FRAME_CHECK_EN: honours s.tlast for resync and adds frame_err.
module axis_rgb_window3x3
    import axis_rgb_window3x3_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_rgb_window3x3_if.slave   s,
    axis_rgb_window3x3_if.master  m
`ifdef FRAME_CHECK_EN
    ,
    output logic                  frame_err
`endif
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    window_t          win_q, win_d;
    pixel_t           lbMid, lbTop;
    logic             accept, lastPos, winOk, resync;
    logic             mValid_q, mValid_d;
    logic             mLast_q, mLast_d;
    window_t          mData_q, mData_d;

    assign s.tready = !mValid_q || m.tready;
    assign accept   = s.tvalid && s.tready;
    assign lastPos  = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
    assign winOk    = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

`ifdef FRAME_CHECK_EN
    logic frameErr_q;

    assign resync    = lastPos || s.tlast;
    assign frame_err = frameErr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frameErr_q <= 1'b0;
        end else begin
            frameErr_q <= accept && (s.tlast != lastPos);
        end
    end
`else
    logic unusedTlast;

    assign resync      = lastPos;
    assign unusedTlast = s.tlast;
`endif

    axis_line_buffer2 #(
        .IMG_W (IMG_W)
    ) u_lineBuf (
        .clk    (clk),
        .wrEn_i (accept),
        .col_i  (col_q),
        .pix_i  (s.tdata),
        .lb0_o  (lbMid),
        .lb1_o  (lbTop)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (resync) begin
                col_d = '0;
                row_d = '0;
            end else if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Shift the window left and insert the new column {top, middle, incoming}.
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < 3; r++) begin
            win_d[winOffset(r, 0) +: PIX_W] = win_q[winOffset(r, 1) +: PIX_W];
            win_d[winOffset(r, 1) +: PIX_W] = win_q[winOffset(r, 2) +: PIX_W];
        end
        win_d[winOffset(0, 2) +: PIX_W] = lbTop;
        win_d[winOffset(1, 2) +: PIX_W] = lbMid;
        win_d[winOffset(2, 2) +: PIX_W] = s.tdata;
    end

    always_comb begin
        mValid_d = mValid_q;
        mLast_d  = mLast_q;
        mData_d  = mData_q;
        if (winOk) begin
            mValid_d = 1'b1;
            mLast_d  = lastPos;
            mData_d  = win_d;
        end else if (mValid_q && m.tready) begin
            mValid_d = 1'b0;
            mLast_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= win_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            mValid_q <= 1'b0;
            mLast_q  <= 1'b0;
            mData_q  <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            mValid_q <= mValid_d;
            mLast_q  <= mLast_d;
            mData_q  <= mData_d;
        end
    end

    assign m.tvalid = mValid_q;
    assign m.tlast  = mLast_q;
    assign m.tdata  = mData_q;

endmodule

// File: tb/tb_axis_rgb_window3x3.sv
// Directed bench for axis_rgb_window3x3: 32x32 main instance plus a 5x4 instance.
`timescale 1ns/1ps
module tb_axis_rgb_window3x3;
    import axis_rgb_window3x3_pkg::*;

    localparam int W    = 32;
    localparam int H    = 32;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);
    localparam int SW   = 5;
    localparam int SH   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_rgb_window3x3_if #(.DATA_W(PIX_W)) sIf ();
    axis_rgb_window3x3_if #(.DATA_W(WIN_W)) mIf ();
    axis_rgb_window3x3_if #(.DATA_W(PIX_W)) sSm ();
    axis_rgb_window3x3_if #(.DATA_W(WIN_W)) mSm ();

`ifdef FRAME_CHECK_EN
    logic frameErr, frameErrSm;
`endif

    axis_rgb_window3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (sIf),
        .m     (mIf)
`ifdef FRAME_CHECK_EN
        ,
        .frame_err (frameErr)
`endif
    );

    axis_rgb_window3x3 #(.IMG_W(SW), .IMG_H(SH)) dutSmall (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (sSm),
        .m     (mSm)
`ifdef FRAME_CHECK_EN
        ,
        .frame_err (frameErrSm)
`endif
    );

    int checks = 0;
    int fails  = 0;

    task automatic checkOutput(input string tag, input window_t obs, input window_t exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pixel_t pix(input int p);
        logic [15:0] v;
        v = p[15:0];
        return {v[7:0], v[7:0] ^ 8'hFF, v[15:8]};
    endfunction

    // Window n (raster order over valid positions) of a frame whose pixel 0 is 'base'.
    function automatic window_t expWin(input int base, input int n, input int w);
        int      orow;
        int      oc;
        window_t r;
        orow = n / (w - 2);
        oc   = n % (w - 2);
        r    = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                r[winOffset(i, j) +: PIX_W] = pix(base + (orow + i) * w + oc + j);
        return r;
    endfunction

    // Downstream ready: constant or random, driven just after each rising edge.
    bit randReady = 1'b0;
    always @(posedge clk) begin
        #1;
        mIf.tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard for the main instance: frame bases queued by the driver.
    int      baseQ[$];
    int      winCnt   = 0;
    int      winTotal = 0;
    bit      held     = 1'b0;
    window_t heldData;
    logic    heldLast;

    always @(negedge clk) begin
        if (!rst_n) begin
            winCnt = 0;
            held   = 1'b0;
        end else if (mIf.tvalid) begin
            if (held) begin
                checkOutput("stall_data", mIf.tdata, heldData);
                checkOutput("stall_last", WIN_W'(mIf.tlast), heldLast);
            end
            if (mIf.tready) begin
                if (baseQ.size() == 0) begin
                    checkOutput("window_without_frame", WIN_W'(baseQ.size()), 1);
                end else begin
                    checkOutput("win_data", mIf.tdata, expWin(baseQ[0], winCnt, W));
                    checkOutput("win_last", WIN_W'(mIf.tlast), WIN_W'(winCnt == NWIN - 1));
                    winCnt++;
                    winTotal++;
                    if (winCnt == NWIN) begin
                        winCnt = 0;
                        void'(baseQ.pop_front());
                    end
                end
                held = 1'b0;
            end else begin
                held     = 1'b1;
                heldData = mIf.tdata;
                heldLast = mIf.tlast;
            end
        end
    end

    window_t smData[$];
    logic    smLast[$];
    always @(negedge clk) begin
        if (rst_n && mSm.tvalid && mSm.tready) begin
            smData.push_back(mSm.tdata);
            smLast.push_back(mSm.tlast);
        end
    end

`ifdef FRAME_CHECK_EN
    int errPulses = 0;
    always @(negedge clk) if (rst_n && (frameErr || frameErrSm)) errPulses++;
`endif

    task automatic sendPixel(input pixel_t d, input logic last);
        bit rdy;
        int budget;
        budget      = 0;
        sIf.tvalid  = 1'b1;
        sIf.tdata   = d;
        sIf.tlast   = last;
        do begin
            @(negedge clk);
            rdy = sIf.tready;
            @(posedge clk);
            #1;
            budget++;
        end while (!rdy && budget < 1000);
        if (!rdy) checkOutput("accept_timeout", WIN_W'(rdy), 1);
    endtask

    task automatic applyStimulus(input int base, input int nPix, input bit randValid,
                                 input bit latCheck);
        window_t firstWin;
        firstWin = {pix(66), pix(65), pix(64), pix(34), pix(33), pix(32), pix(2), pix(1), pix(0)};
        baseQ.push_back(base);
        for (int i = 0; i < nPix; i++) begin
            if (randValid && $urandom_range(0, 1) == 1) begin
                sIf.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            sendPixel(pix(base + i), i == NPIX - 1);
            if (latCheck && i == 65) checkOutput("no_win_before_66", WIN_W'(mIf.tvalid), 0);
            if (latCheck && i == 66) begin
                checkOutput("latency_valid", WIN_W'(mIf.tvalid), 1);
                checkOutput("first_win", mIf.tdata, firstWin);
            end
        end
        sIf.tvalid = 1'b0;
    endtask

    task automatic drain();
        randReady = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        sIf.tvalid = 1'b0;
        sIf.tdata  = '0;
        sIf.tlast  = 1'b0;
        sSm.tvalid = 1'b0;
        sSm.tdata  = '0;
        sSm.tlast  = 1'b0;
        mSm.tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_tvalid", WIN_W'(mIf.tvalid), 0);
        checkOutput("reset_tlast", WIN_W'(mIf.tlast), 0);
        checkOutput("reset_tdata", mIf.tdata, '0);
        checkOutput("reset_tready", WIN_W'(sIf.tready), 1);
        rst_n = 1'b1;

        $display("[TB] full-throughput ramp frame");
        t0 = winTotal;
        applyStimulus(0, NPIX, 1'b0, 1'b1);
        drain();
        checkOutput("s1_count", WIN_W'(winTotal - t0), NWIN);

        $display("[TB] random valid/ready frame");
        t0        = winTotal;
        randReady = 1'b1;
        applyStimulus(1024, NPIX, 1'b1, 1'b0);
        drain();
        checkOutput("s2_count", WIN_W'(winTotal - t0), NWIN);

        $display("[TB] back-to-back frames");
        t0        = winTotal;
        randReady = 1'b1;
        applyStimulus(2048, NPIX, 1'b0, 1'b0);
        applyStimulus(3072, NPIX, 1'b0, 1'b0);
        drain();
        checkOutput("s3_count", WIN_W'(winTotal - t0), 2 * NWIN);

        $display("[TB] reset after 500 pixels");
        t0 = winTotal;
        applyStimulus(4096, 500, 1'b0, 1'b0);
        drain();
        checkOutput("s4_partial_count", WIN_W'(winTotal - t0), 408);
        void'(baseQ.pop_front());
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("s4_reset_tvalid", WIN_W'(mIf.tvalid), 0);
        t0 = winTotal;
        applyStimulus(0, NPIX, 1'b0, 1'b1);
        drain();
        checkOutput("s4_count", WIN_W'(winTotal - t0), NWIN);
        checkOutput("frames_consumed", WIN_W'(baseQ.size()), 0);

        $display("[TB] 5x4 frame");
        for (int i = 0; i < SW * SH; i++) begin
            sSm.tvalid = 1'b1;
            sSm.tdata  = pix(i);
            sSm.tlast  = (i == SW * SH - 1);
            @(posedge clk);
            #1;
        end
        sSm.tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("small_count", WIN_W'(smData.size()), 6);
        for (int n = 0; n < 6; n++) begin
            if (n < smData.size()) begin
                checkOutput("small_data", smData[n], expWin(0, n, SW));
                checkOutput("small_last", WIN_W'(smLast[n]), WIN_W'(n == 5));
            end
        end

`ifdef FRAME_CHECK_EN
        checkOutput("no_frame_err", WIN_W'(errPulses), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
